// File: rtl/cpu_pkg.sv
// Shared CPU types for the HI/LO controller.
// State encoding, read selects and default timeouts.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV_RUN,
    MULT_RUN,
    COMMIT
  } hilo_state_t;

  localparam logic RD_LO = 1'b0;
  localparam logic RD_HI = 1'b1;

  localparam int DIV_TIMEOUT_DEF  = 40;
  localparam int MULT_TIMEOUT_DEF = 40;

endpackage

// File: rtl/hilo_ctrl_if.sv
// Control-unit, divider and multiplier signals of the HI/LO block.
// master drives requests and engine results, slave is the controller.
interface hilo_ctrl_if;

  logic        start_div;
  logic        start_mult;
  logic [31:0] op_b;
  logic        div_go;
  logic        mult_go;
  logic        div_done;
  logic [31:0] div_hi;
  logic [31:0] div_lo;
  logic        mult_done;
  logic [31:0] mult_hi;
  logic [31:0] mult_lo;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wr_data;
  logic        rd_req;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        stall;
  logic        div_zero_exc;
  logic        timeout_err;

  modport master (
    output start_div, start_mult, op_b,
    output div_done, div_hi, div_lo,
    output mult_done, mult_hi, mult_lo,
    output mthi, mtlo, wr_data,
    output rd_req, rd_sel,
    input  div_go, mult_go, rd_data, rd_valid,
    input  busy, stall, div_zero_exc, timeout_err
  );

  modport slave (
    input  start_div, start_mult, op_b,
    input  div_done, div_hi, div_lo,
    input  mult_done, mult_hi, mult_lo,
    input  mthi, mtlo, wr_data,
    input  rd_req, rd_sel,
    output div_go, mult_go, rd_data, rd_valid,
    output busy, stall, div_zero_exc, timeout_err
  );

endinterface

// File: rtl/hilo_regfile.sv
// HI/LO storage with result load, MTHI/MTLO writes
// and a registered read port (reads see pre-write values).
module hilo_regfile
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ld,
  input  logic [31:0] ld_hi,
  input  logic [31:0] ld_lo,
  input  logic        we_hi,
  input  logic        we_lo,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        rd_valid
);

  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (ld) begin
      hi_d = ld_hi;
      lo_d = ld_lo;
    end else begin
      if (we_hi) hi_d = wr_data;
      if (we_lo) lo_d = wr_data;
    end
  end

  always_comb begin
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_en;
    if (rd_en)
      rd_data_d = (rd_sel == RD_HI) ? hi_q : lo_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q       <= '0;
      lo_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO controller: launches div/mult, captures results,
// serves MFHI/MFLO/MTHI/MTLO and flags stalls and timeouts.
module hilo_ctrl
  import cpu_pkg::*;
#(
  parameter int DIV_TIMEOUT  = DIV_TIMEOUT_DEF,
  parameter int MULT_TIMEOUT = MULT_TIMEOUT_DEF
) (
  input logic        clk,
  input logic        reset,
  hilo_ctrl_if.slave bus
);

  localparam logic [7:0] DIV_TMO  = 8'(DIV_TIMEOUT);
  localparam logic [7:0] MULT_TMO = 8'(MULT_TIMEOUT);

  hilo_state_t state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        div_go_q, div_go_d;
  logic        mult_go_q, mult_go_d;
  logic        dz_q, dz_d;
  logic        to_q, to_d;

  logic        idle_ok, run;
  logic        launch_div, launch_mult, zero_div;
  logic [7:0]  cnt_inc;
  logic        div_tmo, mult_tmo;
  logic        ld;
  logic [31:0] ld_hi, ld_lo;
  logic        we_hi, we_lo, rd_en;
  logic        req_any;

  assign idle_ok = (state_q == IDLE) || (state_q == COMMIT);
  assign run     = (state_q == DIV_RUN) || (state_q == MULT_RUN);
  assign cnt_inc = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  assign launch_div  = idle_ok && bus.start_div && (bus.op_b != '0);
  assign zero_div    = idle_ok && bus.start_div && (bus.op_b == '0);
  assign launch_mult = idle_ok && bus.start_mult && !bus.start_div;

  // Result arriving on the last allowed cycle still wins over timeout.
  assign div_tmo  = (state_q == DIV_RUN) && !bus.div_done
                    && (cnt_inc == DIV_TMO);
  assign mult_tmo = (state_q == MULT_RUN) && !bus.mult_done
                    && (cnt_inc == MULT_TMO);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      div_go_q  <= 1'b0;
      mult_go_q <= 1'b0;
      dz_q      <= 1'b0;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_go_q  <= div_go_d;
      mult_go_q <= mult_go_d;
      dz_q      <= dz_d;
      to_q      <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, COMMIT: begin
        unique case (1'b1)
          launch_div:  state_d = DIV_RUN;
          launch_mult: state_d = MULT_RUN;
          default:     state_d = IDLE;
        endcase
      end
      DIV_RUN: begin
        if (bus.div_done) state_d = COMMIT;
        else if (div_tmo) state_d = IDLE;
      end
      MULT_RUN: begin
        if (bus.mult_done) state_d = COMMIT;
        else if (mult_tmo) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    div_go_d  = launch_div;
    mult_go_d = launch_mult;
    dz_d      = zero_div;
    to_d      = to_q || div_tmo || mult_tmo;
    ld        = 1'b0;
    ld_hi     = bus.div_hi;
    ld_lo     = bus.div_lo;
    if (launch_div || launch_mult) cnt_d = '0;
    else if (run) cnt_d = cnt_inc;
    if (state_q == DIV_RUN) begin
      ld = bus.div_done;
    end else if (state_q == MULT_RUN) begin
      ld    = bus.mult_done;
      ld_hi = bus.mult_hi;
      ld_lo = bus.mult_lo;
    end
  end

  assign we_hi   = idle_ok && bus.mthi;
  assign we_lo   = idle_ok && bus.mtlo;
  assign rd_en   = idle_ok && bus.rd_req;
  assign req_any = bus.start_div || bus.start_mult || bus.rd_req
                   || bus.mthi || bus.mtlo;

  hilo_regfile u_regfile (
    .clk      (clk),
    .reset    (reset),
    .ld       (ld),
    .ld_hi    (ld_hi),
    .ld_lo    (ld_lo),
    .we_hi    (we_hi),
    .we_lo    (we_lo),
    .wr_data  (bus.wr_data),
    .rd_en    (rd_en),
    .rd_sel   (bus.rd_sel),
    .rd_data  (bus.rd_data),
    .rd_valid (bus.rd_valid)
  );

  assign bus.div_go       = div_go_q;
  assign bus.mult_go      = mult_go_q;
  assign bus.div_zero_exc = dz_q;
  assign bus.timeout_err  = to_q;
  assign bus.busy         = run;
  assign bus.stall        = run && req_any;

endmodule

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
- Sits directly downstream of the iterative divider and the multiplier in the multicycle CPU datapath.
- Launches div/mult operations on request from the control unit.
- Captures their 32-bit hi/lo results into the architectural HI and LO registers and serves MFHI/MFLO/MTHI/MTLO.
- Raises stall, divide-by-zero and timeout indications back to the control unit.

Parameters:
- DIV_TIMEOUT, 40, max cycles to wait for div_done before flagging timeout_err.
- MULT_TIMEOUT, 40, max cycles to wait for mult_done before flagging timeout_err.

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-low reset
- start_div  in  1  control unit requests DIV (one-cycle pulse)
- start_mult  in  1  control unit requests MULT (one-cycle pulse)
- op_b  in  32  divisor/second operand, sampled with start_div
- div_go  out  1  one-cycle launch pulse to divider
- mult_go  out  1  one-cycle launch pulse to multiplier
- div_done  in  1  divider result valid (pulse)
- div_hi  in  32  divider hi result
- div_lo  in  32  divider lo result
- mult_done  in  1  multiplier result valid (pulse)
- mult_hi  in  32  multiplier hi result
- mult_lo  in  32  multiplier lo result
- mthi  in  1  write wr_data into HI
- mtlo  in  1  write wr_data into LO
- wr_data  in  32  data for MTHI/MTLO
- rd_req  in  1  MFHI/MFLO request
- rd_sel  in  1  0=LO, 1=HI
- rd_data  out  32  selected register value
- rd_valid  out  1  rd_data valid this cycle
- busy  out  1  operation in flight
- stall  out  1  control unit must hold current instruction
- div_zero_exc  out  1  one-cycle pulse on divide by zero
- timeout_err  out  1  sticky until reset

Behaviour:
- Reset (reset==0 at posedge): state IDLE; HI=LO=0; rd_data=0; all pulses, busy, stall and timeout_err 0; timeout counter 0. Applies mid-operation too: the in-flight result is discarded, and a done pulse arriving after reset in IDLE is ignored.
- State IDLE:
  - start_div with op_b!=0 -> div_go=1 next cycle, go DIV_RUN.
  - start_div with op_b==0 -> div_zero_exc=1 next cycle, no launch, HI/LO unchanged, stay IDLE.
  - start_mult -> mult_go=1 next cycle, go MULT_RUN.
  - start_div and start_mult in the same cycle: divide wins, the mult request is dropped.
- State DIV_RUN:
  - busy=1; counter increments each cycle.
  - div_done -> latch div_hi into HI and div_lo into LO at that posedge, go COMMIT.
  - counter reaches DIV_TIMEOUT -> set timeout_err, HI/LO unchanged, go IDLE.
  - mult_done is ignored.
- State MULT_RUN: same as DIV_RUN using mult_done/mult_hi/mult_lo and MULT_TIMEOUT.
- State COMMIT: busy=0, one cycle, go IDLE. New HI/LO are visible to reads from this cycle on.
- Starts while busy (DIV_RUN/MULT_RUN): stall=1, no launch. The control unit keeps holding the start pulse and the start is re-evaluated in IDLE.
- Reads:
  - In IDLE/COMMIT: rd_req gives rd_valid=1 and rd_data=HI or LO on the next cycle (1-cycle latency); rd_data is registered and holds its last value otherwise.
  - In DIV_RUN/MULT_RUN: rd_req drives stall=1 combinationally and rd_valid=0.
- Writes (MTHI/MTLO):
  - In IDLE/COMMIT: take effect at the posedge.
  - While busy: stall=1, write not performed.
  - mthi and mtlo together write both registers.
  - MTHI/MTLO in the same cycle as start_div/start_mult: the write is performed, then the operation launches.
- Read and write of the same register in the same cycle: rd_data returns the old value.
- Counter is 8 bits wide, clears on each launch and saturates (never wraps).

Decomposition:
- Shared package cpu_pkg:
  - typedef enum hilo_state_t {IDLE, DIV_RUN, MULT_RUN, COMMIT};
  - constants RD_LO=0, RD_HI=1.
  - default timeout constants.
- Optional sub-module hilo_regfile: HI/LO storage with write-enable muxing and registered read port.
- The FSM and timeout counter stay in hilo_ctrl.

Test Plan:
- Divide path: start_div with op_b=5 -> div_go at +1; div_done at +33 with hi=2, lo=4 -> HI=2, LO=4; busy falls at +34; MFHI returns 2 with rd_valid one cycle after rd_req.
- Divide by zero: start_div with op_b=0 -> div_zero_exc pulse at +1, no div_go, HI/LO unchanged (preloaded 0xAAAA_AAAA / 0x5555_5555).
- Stall on read: rd_req sel=LO during MULT_RUN -> stall=1, rd_valid=0 until COMMIT; then LO equals mult_lo=0x0000_0F00.
- Timeout: start_mult and never assert mult_done -> timeout_err set after 40 cycles, state IDLE, HI/LO unchanged, timeout_err stays 1.
- Reset mid-op: reset low during DIV_RUN cycle 10 -> HI=LO=0, busy=0; a late div_done is ignored and HI/LO stay 0.
- Simultaneous events: start_div and start_mult together -> only div_go. mthi=1 with wr_data=0x1234 in IDLE -> next-cycle MFHI returns 0x1234.
